mic_clock_gen: RTL
==================

Name: mic_clock_gen

Overview:
- Sits directly downstream of the 12→45 MHz PLL and runs on its 45 MHz output.
- Synchronises the PLL lock flag and holds the mic-domain reset until lock has been stable.
- Once released, generates the I2S-style microphone bit clock (sck), word select (ws), and single-cycle capture/frame strobes for the mic receive logic.

Parameters:
LOCK_WAIT, 1024, clk cycles that the synchronised lock must stay high before the domain reset is released (≥1)
SCK_DIV, 8, clk cycles per sck half-period (≥2); default gives 2.8125 MHz sck
BITS_PER_FRAME, 64, sck cycles per ws frame (even, power of two, ≥4)

Ports:
clock  in  1  45 MHz PLL output clock
reset  in  1  synchronous, active-high
locked  in  1  PLL lock, asynchronous to clock
rst_out  out  1  mic-domain reset, active-high
sck  out  1  mic bit clock
ws  out  1  word select: 0 = left half, 1 = right half
sck_rise  out  1  one-cycle pulse in the cycle sck first reads 1
sck_fall  out  1  one-cycle pulse in the cycle sck first reads 0
bit_index  out  log2(BITS_PER_FRAME)  sck bit position within frame
frame_start  out  1  one-cycle pulse, coincides with sck_fall when bit_index becomes 0

Behaviour:
- All outputs are registered. Reset values: rst_out=1, sck=0, ws=0, sck_rise=0, sck_fall=0, bit_index=0, frame_start=0. Reset also clears all counters, clears both sync flops, and forces state WAIT_LOCK. Reset has priority over everything else.
- locked passes through a 2-flop synchroniser to produce lk_s. Only lk_s is used internally.
- State machine:
  - WAIT_LOCK: stable counter = 0; rst_out = 1; generator held at its reset values. Go to COUNT when lk_s = 1.
  - COUNT: stable counter increments each cycle while lk_s = 1. If lk_s = 0, return to WAIT_LOCK and clear the counter. When the counter reaches LOCK_WAIT-1 with lk_s = 1, go to RUN.
  - RUN: rst_out = 0 from the first RUN cycle. If lk_s = 0, go to WAIT_LOCK on the next edge: rst_out = 1 in that same cycle, and sck, ws, bit_index, the divider and all strobes return to their reset values together.
- Release latency: rst_out falls exactly 2+LOCK_WAIT edges after the first edge that samples locked high, provided locked stays high.
- Divider, active only in RUN:
  - div_cnt starts at 0 on RUN entry and increments each cycle.
  - At div_cnt = SCK_DIV-1: div_cnt wraps to 0 and sck toggles.
  - First sck rise is registered SCK_DIV cycles after RUN entry. sck period = 2·SCK_DIV cycles, 50% duty.
- sck_rise / sck_fall: registered alongside the toggle, so each pulse is high in the same cycle as the new sck level. Never both high. Never high outside RUN.
- bit_index: increments by 1 on each sck_fall and wraps from BITS_PER_FRAME-1 to 0. It is constant between falls, so it is stable and valid at every sck_rise.
- ws = (bit_index ≥ BITS_PER_FRAME/2). It therefore changes only on sck_fall.
- frame_start: pulses on the sck_fall where bit_index wraps to 0. The first RUN frame has no frame_start; its bit_index begins at 0.
- Simultaneous events: a lock loss in the same cycle as a divider wrap aborts the wrap, and no strobe is emitted. Glitches on locked shorter than 1 cycle may be missed; this is acceptable.

Test Plan:
- Params LOCK_WAIT=16, SCK_DIV=4, BITS_PER_FRAME=8. Hold reset 3 cycles with locked=1 → all outputs at reset values. After reset drops, rst_out falls 18 edges after the first sample of locked=1.
- locked high for 10 cycles, low for 1, then high → the count restarts. rst_out falls 18 edges after the final rise; no sck edges appear before that.
- In RUN → first sck rise 4 cycles after RUN entry; sck period 8 cycles; sck_rise and sck_fall are single-cycle and aligned to the new sck level.
- Observe 2 frames → bit_index steps 0..7 on falls; ws=1 for bit_index 4..7; frame_start pulses once every 64 cycles, together with sck_fall at the 7→0 wrap.
- Drop locked mid-frame (bit_index=5) → 2 cycles later rst_out=1 and sck/ws/bit_index=0. Re-raising locked repeats the full 18-edge release.
- Assert reset for 1 cycle in RUN with sck=1 → next cycle all outputs at reset values and state WAIT_LOCK; with locked still high, rst_out falls 18 edges after reset deasserts.

Source files
------------

// File: rtl/mic_clock_gen.sv
// mic_clock_gen: synchronises PLL lock, holds the mic-domain reset until lock is stable,
// then generates sck, ws, bit_index and single-cycle sck/frame strobes.
module mic_clock_gen #(
    parameter int LOCK_WAIT      = 1024,
    parameter int SCK_DIV        = 8,
    parameter int BITS_PER_FRAME = 64,
    localparam int BW = $clog2(BITS_PER_FRAME)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          locked,
    output logic          rst_out,
    output logic          sck,
    output logic          ws,
    output logic          sck_rise,
    output logic          sck_fall,
    output logic [BW-1:0] bit_index,
    output logic          frame_start
);
    localparam int CW = $clog2(LOCK_WAIT + 1);
    localparam int DW = $clog2(SCK_DIV);

    typedef enum logic [1:0] {WAIT_LOCK, COUNT, RUN} state_t;

    state_t          state, next;
    logic            s1, lk_s;
    logic [CW-1:0]   stable;
    logic [DW-1:0]   div_cnt;
    logic [BW-1:0]   bi_next;
    logic            run, wrap;

    always_comb begin
        next    = !lk_s ? WAIT_LOCK :
                  state == WAIT_LOCK ? COUNT :
                  (state == COUNT && stable == CW'(LOCK_WAIT - 1)) ? RUN : state;
        run     = state == RUN && lk_s;
        wrap    = run && div_cnt == DW'(SCK_DIV - 1);
        bi_next = bit_index + BW'(1);
    end

    // A lock loss makes run low, so a coincident wrap is dropped with the generator reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1          <= 1'b0;
            lk_s        <= 1'b0;
            state       <= WAIT_LOCK;
            stable      <= '0;
            rst_out     <= 1'b1;
        end else begin
            s1          <= locked;
            lk_s        <= s1;
            state       <= next;
            stable      <= (state == COUNT && next == COUNT) ? stable + CW'(1) : '0;
            rst_out     <= next != RUN;
        end
        if (reset || !run) begin
            div_cnt     <= '0;
            sck         <= 1'b0;
            ws          <= 1'b0;
            sck_rise    <= 1'b0;
            sck_fall    <= 1'b0;
            bit_index   <= '0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= wrap ? '0 : div_cnt + DW'(1);
            sck         <= sck ^ wrap;
            sck_rise    <= wrap && !sck;
            sck_fall    <= wrap && sck;
            bit_index   <= (wrap && sck) ? bi_next : bit_index;
            ws          <= (wrap && sck) ? bi_next[BW-1] : ws;
            frame_start <= wrap && sck && bit_index == BW'(BITS_PER_FRAME - 1);
        end
    end
endmodule
